// File: rtl/mem_queue_if.sv
// Issue-side and CDB-side signal bundle of the queued memory functional unit.
// The slave modport is the unit's view; the master modport is the environment's view.
interface mem_queue_if #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int Q_DEPTH = 4
);
  localparam int OCC_W = $clog2(Q_DEPTH) + 1;

  logic              issue_valid;
  logic              issue_op;
  logic [DATA_W-1:0] issue_base;
  logic [DATA_W-1:0] issue_offset;
  logic [DATA_W-1:0] issue_wdata;
  logic [TAG_W-1:0]  issue_tag;
  logic              issue_ready;
  logic              cdb_req;
  logic              cdb_grant;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  issue_valid, issue_op, issue_base, issue_offset, issue_wdata, issue_tag, cdb_grant,
    output issue_ready, cdb_req, cdb_tag, cdb_data, occupancy
  );

  modport master (
    output issue_valid, issue_op, issue_base, issue_offset, issue_wdata, issue_tag, cdb_grant,
    input  issue_ready, cdb_req, cdb_tag, cdb_data, occupancy
  );
endinterface

// File: rtl/mem_queue_unit.sv
// In-order queued load/store unit: FIFO of pending ops, multi-cycle access to an
// internal word-addressed RAM, and load results broadcast on the CDB via req/grant.
module mem_queue_unit #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 8,
  parameter int Q_DEPTH = 4,
  parameter int MEM_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [OCC_W-1:0]  count_reg;
  logic [TAG_W-1:0]  res_tag_reg;
  logic [DATA_W-1:0] res_data_reg;

  logic              q_op_reg    [Q_DEPTH];
  logic [DATA_W-1:0] q_base_reg  [Q_DEPTH];
  logic [DATA_W-1:0] q_offset_reg[Q_DEPTH];
  logic [DATA_W-1:0] q_wdata_reg [Q_DEPTH];
  logic [TAG_W-1:0]  q_tag_reg   [Q_DEPTH];

  logic [DATA_W-1:0] ram [2**IDX_W];

  logic              push;
  logic              pop;
  logic              exec_done;
  logic              ram_we;
  logic              ram_re;
  logic              head_op;
  logic [DATA_W-1:0] ea;
  logic [IDX_W-1:0]  idx;
  logic              unused_ea_bits;

  assign bus.issue_ready = (count_reg != OCC_W'(Q_DEPTH));
  assign bus.occupancy   = count_reg;
  assign bus.cdb_req     = (state_reg == ST_WAIT);
  assign bus.cdb_tag     = bus.cdb_req ? res_tag_reg  : '0;
  assign bus.cdb_data    = bus.cdb_req ? res_data_reg : '0;

  assign push = bus.issue_valid && bus.issue_ready;

  // Head fields and effective address; the carry out of the add is discarded.
  assign head_op        = q_op_reg[rd_ptr_reg];
  assign ea             = q_base_reg[rd_ptr_reg] + q_offset_reg[rd_ptr_reg];
  assign idx            = ea[IDX_W+1:2];
  assign unused_ea_bits = ^{ea[DATA_W-1:IDX_W+2], ea[1:0]};

  assign exec_done = (state_reg == ST_EXEC) && (cnt_reg == '0);
  assign ram_we    = exec_done && !head_op && !rst;
  assign ram_re    = exec_done && head_op;
  assign pop       = (exec_done && !head_op) || ((state_reg == ST_WAIT) && bus.cdb_grant);

  // Per-entry payload storage; only the entry under the write pointer loads.
  for (genvar gi = 0; gi < Q_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        q_op_reg[gi]     <= bus.issue_op;
        q_base_reg[gi]   <= bus.issue_base;
        q_offset_reg[gi] <= bus.issue_offset;
        q_wdata_reg[gi]  <= bus.issue_wdata;
        q_tag_reg[gi]    <= bus.issue_tag;
      end
    end
  end

  // RAM contents survive reset; only the write strobe is suppressed by it.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= q_wdata_reg[rd_ptr_reg];
    end
    if (ram_re) begin
      res_data_reg <= ram[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      res_tag_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + OCC_W'(1);
        2'b01:   count_reg <= count_reg - OCC_W'(1);
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        ST_IDLE: begin
          if (count_reg != '0) begin
            state_reg <= ST_EXEC;
            cnt_reg   <= CNT_W'(MEM_LAT - 1);
          end
        end
        ST_EXEC: begin
          if (cnt_reg == '0) begin
            if (head_op) begin
              state_reg   <= ST_WAIT;
              res_tag_reg <= q_tag_reg[rd_ptr_reg];
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (bus.cdb_grant) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_queue_unit.sv
// Directed bench for mem_queue_unit: store/load ordering, queue fill, CDB stall,
// address wrap/aliasing, reset during an access, and simultaneous push/pop.
module tb_mem_queue_unit;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 8;
  localparam int Q_DEPTH = 4;
  localparam int MEM_LAT = 3;
  localparam int TAG_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   n;

  always #5 clk = ~clk;

  mem_queue_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .Q_DEPTH(Q_DEPTH)) bus ();

  mem_queue_unit #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .Q_DEPTH(Q_DEPTH), .MEM_LAT(MEM_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] wdata, input logic [3:0] tag);
    bus.issue_valid  = 1'b1;
    bus.issue_op     = op;
    bus.issue_base   = base;
    bus.issue_offset = off;
    bus.issue_wdata  = wdata;
    bus.issue_tag    = tag;
    step();
    bus.issue_valid  = 1'b0;
    $display("issue op=%0d base=%h off=%h wdata=%h tag=%0d occ=%0d",
             op, base, off, wdata, tag, bus.occupancy);
  endtask

  // Returns the number of edges until cdb_req is seen, or -1 on timeout.
  task automatic wait_req(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.cdb_req) begin
        cycles = i;
        break;
      end
    end
    $display("cdb_req after %0d cycles tag=%0d data=%h", cycles, bus.cdb_tag, bus.cdb_data);
  endtask

  task automatic grant_once();
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
    $display("grant occ=%0d cdb_req=%0d", bus.occupancy, bus.cdb_req);
  endtask

  initial begin
    bus.issue_valid  = 1'b0;
    bus.issue_op     = 1'b0;
    bus.issue_base   = '0;
    bus.issue_offset = '0;
    bus.issue_wdata  = '0;
    bus.issue_tag    = '0;
    bus.cdb_grant    = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_req",   32'(bus.cdb_req),     32'd0);
    chk("rst_tag",   32'(bus.cdb_tag),     32'd0);
    chk("rst_data",  bus.cdb_data,         32'd0);
    chk("rst_occ",   32'(bus.occupancy),   32'd0);

    // Store then load to ea=12 (index 3)
    issue(1'b0, 32'd4, 32'd8, 32'h12345678, 4'd0);
    chk("st_occ1", 32'(bus.occupancy), 32'd1);
    issue(1'b1, 32'd4, 32'd8, 32'h0, 4'd3);
    chk("ld_occ2", 32'(bus.occupancy), 32'd2);
    step(); step(); step();
    chk("st_popped_occ", 32'(bus.occupancy), 32'd1);
    chk("req_low_at_head", 32'(bus.cdb_req), 32'd0);
    wait_req(n);
    chk("ld_latency", 32'(n), 32'(MEM_LAT + 1));
    chk("ld_tag",  32'(bus.cdb_tag), 32'd3);
    chk("ld_data", bus.cdb_data,     32'h12345678);

    // Grant stall: outputs hold for 10 cycles without grant
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_req",  32'(bus.cdb_req), 32'd1);
      chk("stall_tag",  32'(bus.cdb_tag), 32'd3);
      chk("stall_data", bus.cdb_data,     32'h12345678);
    end
    chk("stall_occ", 32'(bus.occupancy), 32'd1);
    grant_once();
    chk("grant_req_drop", 32'(bus.cdb_req),   32'd0);
    chk("grant_occ",      32'(bus.occupancy), 32'd0);
    chk("grant_data0",    bus.cdb_data,       32'd0);

    // Stray grant in IDLE and during EXEC is ignored
    bus.cdb_grant = 1'b1;
    step(); step();
    chk("stray_idle_req", 32'(bus.cdb_req),   32'd0);
    chk("stray_idle_occ", 32'(bus.occupancy), 32'd0);
    bus.cdb_grant = 1'b0;
    issue(1'b1, 32'd0, 32'd12, 32'h0, 4'd9);
    bus.cdb_grant = 1'b1;
    step(); step();
    bus.cdb_grant = 1'b0;
    chk("stray_exec_occ", 32'(bus.occupancy), 32'd1);
    wait_req(n);
    chk("stray_exec_lat", 32'(n), 32'd2);
    chk("stray_exec_tag", 32'(bus.cdb_tag), 32'd9);
    grant_once();

    // Fill the queue with four loads, fifth is dropped
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'd0, 32'd12, 32'h0, 4'(4 + i));
    end
    chk("full_occ",   32'(bus.occupancy),   32'd4);
    chk("full_ready", 32'(bus.issue_ready), 32'd0);
    issue(1'b1, 32'd0, 32'd12, 32'h0, 4'd15);
    chk("drop_occ", 32'(bus.occupancy), 32'd4);
    wait_req(n);
    chk("fill_tag0",  32'(bus.cdb_tag), 32'd4);
    chk("fill_data0", bus.cdb_data,     32'h12345678);
    grant_once();
    chk("fill_occ3",   32'(bus.occupancy),   32'd3);
    chk("fill_ready1", 32'(bus.issue_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      wait_req(n);
      chk("fill_tag", 32'(bus.cdb_tag), 32'(4 + i));
      grant_once();
    end
    step(); step(); step(); step(); step(); step();
    chk("fill_drained_occ", 32'(bus.occupancy), 32'd0);
    chk("fill_no_extra_req", 32'(bus.cdb_req), 32'd0);

    // Address wrap: ea = 0xFFFFFFFC + 8 = 4
    issue(1'b0, 32'hFFFFFFFC, 32'd8, 32'hCAFEF00D, 4'd0);
    issue(1'b1, 32'd0, 32'd4, 32'h0, 4'd10);
    wait_req(n);
    chk("wrap_tag",  32'(bus.cdb_tag), 32'd10);
    chk("wrap_data", bus.cdb_data,     32'hCAFEF00D);
    grant_once();

    // Offset 0x401 aliases to index 0
    issue(1'b0, 32'd0, 32'd0, 32'hA5A5A5A5, 4'd0);
    issue(1'b1, 32'd0, 32'h401, 32'h0, 4'd11);
    wait_req(n);
    chk("alias_data", bus.cdb_data, 32'hA5A5A5A5);
    grant_once();

    // Reset on the edge where an in-flight store would write
    issue(1'b0, 32'd8, 32'd0, 32'h11111111, 4'd0);
    for (int i = 0; i < 20 && bus.occupancy != 0; i++) step();
    chk("pre_store_done", 32'(bus.occupancy), 32'd0);
    issue(1'b0, 32'd0, 32'd8, 32'h22222222, 4'd0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("reset mid-exec occ=%0d ready=%0d req=%0d", bus.occupancy, bus.issue_ready, bus.cdb_req);
    chk("midrst_occ",   32'(bus.occupancy),   32'd0);
    chk("midrst_ready", 32'(bus.issue_ready), 32'd1);
    chk("midrst_req",   32'(bus.cdb_req),     32'd0);
    chk("midrst_tag",   32'(bus.cdb_tag),     32'd0);
    chk("midrst_data",  bus.cdb_data,         32'd0);
    issue(1'b1, 32'd8, 32'd0, 32'h0, 4'd2);
    wait_req(n);
    chk("midrst_lat",  32'(n), 32'(MEM_LAT + 1));
    chk("midrst_keep", bus.cdb_data, 32'h11111111);
    grant_once();

    // Push on the same edge a store pops
    issue(1'b0, 32'd0, 32'd16, 32'h5555AAAA, 4'd0);
    step(); step(); step();
    chk("pp_occ_before", 32'(bus.occupancy), 32'd1);
    issue(1'b1, 32'd0, 32'd16, 32'h0, 4'd12);
    chk("pp_occ_after", 32'(bus.occupancy), 32'd1);
    wait_req(n);
    chk("pp_tag",  32'(bus.cdb_tag), 32'd12);
    chk("pp_data", bus.cdb_data,     32'h5555AAAA);
    grant_once();
    chk("pp_final_occ", 32'(bus.occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_queue_unit.md
# mem_queue_unit

Parametrised, queued memory functional unit for the Tomasulo core, successor to the single-entry memory unit. It accepts load/store operations from the reservation-station side into an in-order queue, computes effective addresses (base + offset), performs each access against an internal word-addressed RAM with a configurable multi-cycle latency, and broadcasts load results on the CDB through a request/grant handshake. Stores complete silently. Loads are tag-tracked so results can be matched by waiting stations.

## Interface
- DATA_W, 32, data and address width
- IDX_W, 8, word-index bits; RAM holds 2^IDX_W words
- Q_DEPTH, 4, queue entries (power of two, ≥2)
- MEM_LAT, 3, access cycles per operation (≥1)
- TAG_W, 4, reservation-station tag width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  operation offered this cycle
- issue_op  in  1  1 = load, 0 = store
- issue_base  in  DATA_W  base operand (Qj value)
- issue_offset  in  DATA_W  immediate offset (A)
- issue_wdata  in  DATA_W  store data (ignored for loads)
- issue_tag  in  TAG_W  producer tag for load result
- issue_ready  out  1  queue not full; issue accepted when issue_valid && issue_ready
- cdb_req  out  1  load result pending, requesting CDB
- cdb_grant  in  1  CDB granted to this unit (acknowledge)
- cdb_tag  out  TAG_W  tag of pending result
- cdb_data  out  DATA_W  load data; 0 when cdb_req low
- occupancy  out  $clog2(Q_DEPTH)+1  entries currently queued, including the head

## Operation
- Queue: circular FIFO, Q_DEPTH entries of {op, base, offset, wdata, tag}. Strict program order; no reordering or store-to-load forwarding.
- Effective address: ea = base + offset, modulo 2^DATA_W (carry discarded). Word index = ea[IDX_W+1:2]. ea[1:0] and bits above IDX_W+1 are ignored.
- FSM, on the head entry:
  - IDLE: if the queue is non-empty, go to EXEC with cnt = MEM_LAT-1.
  - EXEC: decrement cnt each cycle. At cnt==0:
    - Store: write RAM[idx] = wdata at that edge, pop the head, and go to IDLE.
    - Load: latch RAM[idx] into the result register and go to WAIT_CDB.
  - WAIT_CDB: cdb_req=1, with cdb_tag and cdb_data held stable. On an edge where cdb_grant=1, pop the head and go to IDLE.
- IDLE with an empty queue is the only quiescent state. A new head always passes through IDLE, so there is 1 bubble cycle between operations.
- Push and pop in the same cycle: both take effect and occupancy is unchanged.
- Push while full is not possible: issue_ready=0, and issue_valid is ignored.
- cdb_grant outside WAIT_CDB is ignored.
- Reset (any cycle, including mid-EXEC or WAIT_CDB):
  - queue flushed, pointers and occupancy reset to 0, FSM set to IDLE;
  - an in-flight store is not written;
  - RAM contents are not cleared.
- Reset values: issue_ready=1, cdb_req=0, cdb_tag=0, cdb_data=0, occupancy=0.

## Timing
- issue_ready and occupancy are registered-state derived: issue_ready = (occupancy != Q_DEPTH), with no same-cycle pop bypass.
- Best-case load into an empty unit, issue sampled at edge E0:
  - IDLE in cycle after E0;
  - EXEC for MEM_LAT cycles;
  - cdb_req rises after edge E0+MEM_LAT+1 (i.e. visible MEM_LAT+1 cycles after acceptance).
- Best-case store into an empty unit, issue sampled at edge E0: RAM written at edge E0+MEM_LAT+1.
- A load queued behind a store to the same index reads the new value.
- Grant sampled at edge G: cdb_req is 0 in the cycle after G unless the next head is a load that has already completed. That cannot happen, because each op needs ≥1 IDLE + MEM_LAT cycles.
- cdb_req is held indefinitely while cdb_grant=0; data and tag stay stable.

## Test plan
- Store then load:
  - stimulus: store base=4, offset=8, wdata=0x12345678, then load base=4, offset=8, tag=3;
  - required: RAM[3] written, then cdb_req with cdb_tag=3, cdb_data=0x12345678;
  - cdb_req first high exactly MEM_LAT+1 cycles after the load reaches the head.
- Fill the queue:
  - stimulus: issue 4 loads back-to-back with cdb_grant=0;
  - required: occupancy reaches 4, issue_ready=0, and a 5th issue is dropped (occupancy stays 4);
  - then grant once: occupancy becomes 3 and issue_ready=1.
- Grant stall:
  - stimulus: hold cdb_grant=0 for 10 cycles while a load is pending, then pulse it for 1 cycle;
  - required: cdb_req, cdb_tag and cdb_data constant throughout; cdb_req drops the cycle after the grant edge;
  - check that a stray grant while in IDLE has no effect.
- Address wrap:
  - stimulus: store 0xCAFEF00D with base=0xFFFFFFFC, offset=8 (ea=4), then load base=0, offset=4;
  - required: cdb_data=0xCAFEF00D;
  - also check that offset=0x401 with IDX_W=8 aliases to index 0.
- Reset mid-operation:
  - stimulus: pre-write RAM[2]=0x11111111, issue store 0x22222222 to ea=8, assert rst during EXEC;
  - required: all outputs return to reset values and queue is empty;
  - a subsequent load of ea=8 returns 0x11111111.
- Simultaneous push and pop:
  - stimulus: issue a new op on the same edge a store completes;
  - required: occupancy unchanged and both ops complete in order.
